game_referee: RTL and testbench



---
 rtl/game_pkg.sv | 19 +
 rtl/event_tally.sv | 37 +++
 rtl/game_referee.sv | 113 +++++++++++
 tb/tb_game_referee.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game referee: FSM states, result codes
// and the counter_main control mode driven when no game is running.
package game_pkg;

  typedef enum logic [2:0] {IDLE, INIT, RUN, DONE, CLEAR} state_t;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_WIN  = 2'b01;
  localparam logic [1:0] WHO_LOSE = 2'b10;
  localparam logic [1:0] WHO_TIE  = 2'b11;

  localparam logic [1:0] CTRL_IDLE = 2'b00;

  // Result code from the post-increment limit hits of the two tallies.
  function automatic logic [1:0] who_code(input logic win_hit, input logic lose_hit);
    return {lose_hit, win_hit};
  endfunction

endpackage

// File: rtl/event_tally.sv
// Saturating event counter with synchronous clear; hit_nxt flags that the
// value being loaded this cycle equals LIMIT, so the caller can act on it
// in the same cycle as the increment.
module event_tally #(
  parameter int CNT_W = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             hit_nxt
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (en && cnt != LIM)
      cnt_nxt = cnt + 1'b1;
  end

  assign hit_nxt = (cnt_nxt == LIM);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/game_referee.sv
// Game referee for counter_main: seeds the counter, tallies winner/loser
// pulses, declares the first side to LIMIT and pulses a clear afterwards.
//
// state | meaning
// IDLE  | waiting for start, outputs quiescent
// INIT  | one-cycle load strobe with captured seed, tallies cleared
// RUN   | counting events, ctrl follows mode
// DONE  | one-cycle game_over, result held
// CLEAR | one-cycle game_rst, then INIT (auto_restart) or IDLE
module game_referee
  import game_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             auto_restart,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic             winner,
  input  logic             loser,
  output logic [1:0]       ctrl,
  output logic             init,
  output logic [WIDTH-1:0] load,
  output logic             game_rst,
  output logic [1:0]       who,
  output logic             game_over,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] lose_cnt,
  output logic [7:0]       games
);

  state_t state;
  logic   enter_init;
  logic   in_run;
  logic   win_hit;
  logic   lose_hit;

  assign enter_init = (state == IDLE && start) || (state == CLEAR && auto_restart);
  assign in_run     = (state == RUN);

  event_tally #(.CNT_W(CNT_W), .LIMIT(LIMIT)) u_win (
    .clk     (clk),
    .reset   (reset),
    .clr     (enter_init),
    .en      (in_run && winner),
    .cnt     (win_cnt),
    .hit_nxt (win_hit)
  );

  event_tally #(.CNT_W(CNT_W), .LIMIT(LIMIT)) u_lose (
    .clk     (clk),
    .reset   (reset),
    .clr     (enter_init),
    .en      (in_run && loser),
    .cnt     (lose_cnt),
    .hit_nxt (lose_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ctrl      <= CTRL_IDLE;
      init      <= 1'b0;
      load      <= '0;
      game_rst  <= 1'b0;
      who       <= WHO_NONE;
      game_over <= 1'b0;
      games     <= 8'd0;
    end else begin
      init      <= 1'b0;
      game_rst  <= 1'b0;
      game_over <= 1'b0;
      if (enter_init) begin
        state <= INIT;
        init  <= 1'b1;
        load  <= seed;
        ctrl  <= mode;
        who   <= WHO_NONE;
      end else begin
        case (state)
          IDLE: ;
          INIT: begin
            state <= RUN;
            load  <= '0;
            ctrl  <= mode;
          end
          RUN: begin
            ctrl <= mode;
            // End of game is judged on the tallies as they will be after this edge.
            if (win_hit || lose_hit) begin
              state     <= DONE;
              who       <= who_code(win_hit, lose_hit);
              game_over <= 1'b1;
              games     <= games + 8'd1;
              ctrl      <= CTRL_IDLE;
            end
          end
          DONE: begin
            state    <= CLEAR;
            game_rst <= 1'b1;
          end
          CLEAR:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_referee.sv
// Self-checking bench for game_referee: directed game scenarios followed by
// randomized play, every cycle compared against a behavioural game model.
module tb_game_referee;

  localparam int WIDTH = 8;
  localparam int LIMIT = 15;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             auto_restart = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] seed = '0;
  logic             winner = 1'b0;
  logic             loser = 1'b0;
  logic [1:0]       ctrl;
  logic             init;
  logic [WIDTH-1:0] load;
  logic             game_rst;
  logic [1:0]       who;
  logic             game_over;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] lose_cnt;
  logic [7:0]       games;

  int n_chk = 0;
  int n_err = 0;

  game_referee #(.WIDTH(WIDTH), .LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .auto_restart (auto_restart),
    .mode         (mode),
    .seed         (seed),
    .winner       (winner),
    .loser        (loser),
    .ctrl         (ctrl),
    .init         (init),
    .load         (load),
    .game_rst     (game_rst),
    .who          (who),
    .game_over    (game_over),
    .win_cnt      (win_cnt),
    .lose_cnt     (lose_cnt),
    .games        (games)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 loading, 2 playing, 3 over, 4 clearing.
  int         phase = 0;
  int         wins = 0;
  int         losses = 0;
  int         played = 0;
  logic [1:0] m_ctrl = 2'b00;
  logic [1:0] m_who = 2'b00;
  logic       m_init = 1'b0;
  logic       m_rst = 1'b0;
  logic       m_over = 1'b0;
  logic [WIDTH-1:0] m_load = '0;

  task automatic model_new_game();
    phase  = 1;
    m_init = 1'b1;
    m_load = seed;
    m_ctrl = mode;
    m_who  = 2'b00;
    wins   = 0;
    losses = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      phase = 0; wins = 0; losses = 0; played = 0;
      m_ctrl = 2'b00; m_who = 2'b00; m_init = 1'b0; m_rst = 1'b0; m_over = 1'b0; m_load = '0;
    end else begin
      m_init = 1'b0;
      m_rst  = 1'b0;
      m_over = 1'b0;
      case (phase)
        0: if (start) model_new_game();
        1: begin phase = 2; m_load = '0; m_ctrl = mode; end
        2: begin
          m_ctrl = mode;
          if (winner && wins < LIMIT) wins = wins + 1;
          if (loser && losses < LIMIT) losses = losses + 1;
          if (wins == LIMIT || losses == LIMIT) begin
            m_who  = (wins == LIMIT && losses == LIMIT) ? 2'b11 : (wins == LIMIT) ? 2'b01 : 2'b10;
            m_over = 1'b1;
            m_ctrl = 2'b00;
            played = (played + 1) % 256;
            phase  = 3;
          end
        end
        3: begin phase = 4; m_rst = 1'b1; end
        default: if (auto_restart) model_new_game(); else phase = 0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("ctrl",      32'(ctrl),      32'(m_ctrl));
    chk("init",      32'(init),      32'(m_init));
    chk("load",      32'(load),      32'(m_load));
    chk("game_rst",  32'(game_rst),  32'(m_rst));
    chk("who",       32'(who),       32'(m_who));
    chk("game_over", 32'(game_over), 32'(m_over));
    chk("win_cnt",   32'(win_cnt),   32'(wins));
    chk("lose_cnt",  32'(lose_cnt),  32'(losses));
    chk("games",     32'(games),     32'(played));
  endtask

  task automatic begin_game(input logic [WIDTH-1:0] s, input logic [1:0] m);
    seed = s; mode = m; start = 1'b1;
    tick();
    chk("init_pulse", 32'(init), 32'd1);
    chk("load_seed",  32'(load), 32'(s));
    start = 1'b0;
    tick();
    chk("init_once", 32'(init), 32'd0);
    chk("ctrl_run",  32'(ctrl), 32'(m));
  endtask

  initial begin
    @(negedge clk);
    tick();
    chk("rst_games", 32'(games), 32'd0);
    reset = 1'b0;

    // Straight win; an extra winner pulse lands in DONE and must be dropped.
    winner = 1'b1;
    tick();
    chk("idle_drop", 32'(win_cnt), 32'd0);
    begin_game(8'h0F, 2'b00);
    winner = 1'b1;
    for (int i = 0; i < LIMIT; i++) tick();
    chk("win_who",  32'(who),       32'd1);
    chk("win_over", 32'(game_over), 32'd1);
    tick();
    winner = 1'b0;
    chk("win_grst", 32'(game_rst), 32'd1);
    chk("win_game", 32'(games),    32'd1);
    tick();
    tick();
    chk("win_hold", 32'(win_cnt), 32'd15);
    chk("win_lose", 32'(lose_cnt), 32'd0);

    // Tie: 14 of each, then both together; start during RUN is ignored.
    begin_game(8'hA5, 2'b10);
    for (int i = 0; i < 28; i++) begin
      winner = (i < 14);
      loser  = (i >= 14);
      start  = (i % 5 == 0);
      mode   = 2'(i);
      tick();
    end
    start = 1'b0; winner = 1'b1; loser = 1'b1;
    tick();
    winner = 1'b0; loser = 1'b0;
    chk("tie_who",  32'(who),      32'd3);
    chk("tie_win",  32'(win_cnt),  32'd15);
    chk("tie_lose", 32'(lose_cnt), 32'd15);
    tick();
    tick();

    // Loss with auto restart, then reset mid-game at win_cnt=7.
    auto_restart = 1'b1;
    begin_game(8'h3C, 2'b01);
    loser = 1'b1;
    for (int i = 0; i < LIMIT; i++) tick();
    loser = 1'b0;
    chk("lose_who", 32'(who), 32'd2);
    seed = 8'h77;
    tick();
    tick();
    chk("ar_init", 32'(init),     32'd1);
    chk("ar_who",  32'(who),      32'd0);
    chk("ar_cnt",  32'(lose_cnt), 32'd0);
    auto_restart = 1'b0;
    tick();
    winner = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    winner = 1'b0;
    chk("pre_rst", 32'(win_cnt), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_cnt",  32'(win_cnt),  32'd0);
    chk("rst_grst", 32'(game_rst), 32'd0);

    // Randomized play.
    for (int c = 0; c < 4000; c++) begin
      start  = ($urandom_range(0, 7) == 0);
      winner = ($urandom_range(0, 2) == 0);
      loser  = ($urandom_range(0, 2) == 0);
      mode   = 2'($urandom_range(0, 3));
      seed   = WIDTH'($urandom);
      reset  = ($urandom_range(0, 399) == 0);
      if (c % 200 == 0) auto_restart = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
